// File: rtl/pll_lock_detect.sv
// pll_lock_detect: counts PLL output cycles per reference period and reports frequency lock
module pll_lock_detect #(
    parameter int CNT_W    = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int GOOD_W   = 3
) (
    input  logic             clockp,
    input  logic             reset,
    input  logic             enable,
    input  logic             osc,
    input  logic [4:0]       div,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid,
    output logic             locked,
    output logic             osc_lost
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
    state_t             state, state_nxt;
    logic               s1, s2, s3;
    logic [CNT_W-1:0]   cnt, div_ext, diff;
    logic [GOOD_W-1:0]  good, good_inc;
    logic               ref_edge, win, sat, in_tol;
    assign ref_edge = s2 & ~s3;
    assign div_ext  = CNT_W'(div);
    assign diff     = cnt >= div_ext ? cnt - div_ext : div_ext - cnt;
    assign in_tol   = |div && diff <= CNT_W'(TOL);
    assign win      = state == MEAS && enable && ref_edge;
    assign sat      = state == MEAS && enable && !ref_edge && cnt == CNT_MAX;
    assign good_inc = good >= GOOD_MAX ? GOOD_MAX : good + 1'b1;
    // state register
    always_ff @(posedge clockp) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    // next state: enable low always returns to IDLE; a missing reference re-arms
    always_comb begin
        state_nxt = state;
        if (!enable)                        state_nxt = IDLE;
        else if (state == IDLE)             state_nxt = ARM;
        else if (state == ARM && ref_edge)  state_nxt = MEAS;
        else if (sat)                       state_nxt = ARM;
    end
    // synchronizer, period counter, window check and lock tracking
    always_ff @(posedge clockp) begin
        if (reset) begin
            {s3, s2, s1} <= '0;
            cnt          <= '0;
            good         <= '0;
            meas         <= '0;
            meas_valid   <= 1'b0;
            locked       <= 1'b0;
            osc_lost     <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, osc};
            meas_valid   <= win;
            if (!enable || state == IDLE) begin
                cnt    <= '0;
                good   <= '0;
                locked <= 1'b0;
            end else begin
                cnt <= ref_edge ? CNT_W'(1) : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
                if (state == ARM && ref_edge) osc_lost <= 1'b0;
                if (win) begin
                    meas   <= cnt;
                    good   <= in_tol ? good_inc : '0;
                    locked <= in_tol && good_inc == GOOD_MAX;
                end
                if (sat) begin
                    osc_lost <= 1'b1;
                    locked   <= 1'b0;
                    good     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pll_lock_detect.sv
// tb_pll_lock_detect: directed and randomized checks of pll_lock_detect against a reference model
module tb_pll_lock_detect;
    logic       clockp = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       osc = 1'b0;
    logic [4:0] div = 5'd8;
    logic [7:0] meas;
    logic       meas_valid, locked, osc_lost;
    int checks = 0, errors = 0;
    int per = 8, ph = 0;
    bit osc_run = 1'b1;
    int cyc = 0, m_mode = 0, m_last = 0, m_good = 0, m_meas = 0;
    bit m_mv = 0, m_locked = 0, m_lost = 0, prev_o = 0, prev_mv = 0;
    int edges[$];

    pll_lock_detect dut (
        .clockp(clockp), .reset(reset), .enable(enable), .osc(osc), .div(div),
        .meas(meas), .meas_valid(meas_valid), .locked(locked), .osc_lost(osc_lost)
    );

    always #5 clockp = ~clockp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // model: osc rises become reference events 2 samples later; windows are edge-to-edge distances
    task automatic model_step();
        bit e;
        int d;
        cyc++;
        m_mv = 0;
        if (reset) begin
            m_mode = 0; m_meas = 0; m_locked = 0; m_lost = 0; m_good = 0; prev_o = 0;
            edges.delete();
            return;
        end
        if (osc && !prev_o) edges.push_back(cyc + 2);
        prev_o = osc;
        e = edges.size() > 0 && edges[0] == cyc;
        if (e) void'(edges.pop_front());
        if (!enable) begin
            m_mode = 0; m_locked = 0; m_good = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (e) begin m_mode = 2; m_last = cyc; m_lost = 0; end
        end else if (e) begin
            m_meas = (cyc - m_last > 255) ? 255 : cyc - m_last;
            m_mv = 1;
            m_last = cyc;
            d = (m_meas > int'(div)) ? m_meas - int'(div) : int'(div) - m_meas;
            if (div != 0 && d <= 1) begin
                m_good = (m_good < 4) ? m_good + 1 : 4;
                m_locked = (m_good == 4);
            end else begin
                m_good = 0; m_locked = 0;
            end
        end else if (cyc - m_last >= 255) begin
            m_mode = 1; m_lost = 1; m_locked = 0; m_good = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clockp);
            ph = ph + 1;
            if (ph >= per) ph = 0;
            osc = osc_run && ph < per / 2;
            @(posedge clockp);
            #1;
            model_step();
            check("meas", meas, m_meas);
            check("meas_valid", meas_valid, m_mv);
            check("locked", locked, m_locked);
            check("osc_lost", osc_lost, m_lost);
            check("mv_back_to_back", meas_valid & prev_mv, 0);
            prev_mv = meas_valid;
        end
    endtask

    initial begin
        run(5);
        reset = 1'b0; enable = 1'b1;
        run(100);
        check("s1_locked", locked, 1);
        check("s1_meas", meas, 8);
        per = 9;
        run(80);
        check("tol9_locked", locked, 1);
        per = 10;
        run(40);
        check("tol10_unlocked", locked, 0);
        check("tol10_meas", meas, 10);
        per = 8;
        run(80);
        osc_run = 1'b0;
        run(300);
        check("lost_flag", osc_lost, 1);
        check("lost_unlocked", locked, 0);
        osc_run = 1'b1;
        run(80);
        check("relock_lost", osc_lost, 0);
        check("relock_locked", locked, 1);
        enable = 1'b0;
        run(10);
        check("dis_locked", locked, 0);
        check("dis_meas_kept", meas, 8);
        enable = 1'b1;
        run(80);
        check("reen_locked", locked, 1);
        run(4);
        reset = 1'b1;
        run(1);
        check("rst_meas", meas, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;
        run(100);
        check("post_rst_locked", locked, 1);
        div = 5'd0;
        run(100);
        check("div0_locked", locked, 0);
        check("div0_meas", meas, 8);
        div = 5'd8; per = 255;
        run(800);
        check("sat_edge_lost", osc_lost, 0);
        check("sat_edge_meas", meas, 255);
        for (int s = 0; s < 25; s++) begin
            int dv;
            per = $urandom_range(4, 14);
            dv = per + int'($urandom_range(0, 4)) - 2;
            div = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'(dv);
            enable = $urandom_range(0, 7) != 0;
            osc_run = $urandom_range(0, 5) != 0;
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                run(2);
                reset = 1'b0;
            end
            run(osc_run ? $urandom_range(20, 150) : 300);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
